// File: rtl/rob_status_table.sv
// rob_status_table: circular reorder-buffer status table with N-wide alloc,
// complete and in-order retire lanes, plus mispredict flush on retirement.
// Ports:
//   clock, reset (async active-low)
//   alloc_cnt -> alloc_idx[N], free_slots         (dispatch side)
//   cmp_valid/idx/mispred/taken/target [N]        (complete side)
//   ret_valid/idx/taken/target [N], flush(+target) (retire side)
module rob_status_table #(
  parameter  int N      = 2,
  parameter  int ROB_SZ = 32,
  localparam int IDX_W  = $clog2(ROB_SZ),
  localparam int AC_W   = $clog2(N + 1),
  localparam int CNT_W  = $clog2(ROB_SZ + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [AC_W-1:0]             alloc_cnt,
  output logic [N-1:0][IDX_W-1:0]     alloc_idx,
  output logic [CNT_W-1:0]            free_slots,
  input  logic [N-1:0]                cmp_valid,
  input  logic [N-1:0][IDX_W-1:0]     cmp_idx,
  input  logic [N-1:0]                cmp_mispred,
  input  logic [N-1:0]                cmp_taken,
  input  logic [N-1:0][31:0]          cmp_target,
  output logic [N-1:0]                ret_valid,
  output logic [N-1:0][IDX_W-1:0]     ret_idx,
  output logic [N-1:0]                ret_taken,
  output logic [N-1:0][31:0]          ret_target,
  output logic                        flush,
  output logic [31:0]                 flush_target
);

  logic [IDX_W-1:0]         head_q, head_d;
  logic [IDX_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [ROB_SZ-1:0]        alloc_q, alloc_d;
  logic [ROB_SZ-1:0]        cmp_q, cmp_d;
  logic [ROB_SZ-1:0]        misp_q, misp_d;
  logic [ROB_SZ-1:0]        taken_q, taken_d;
  logic [ROB_SZ-1:0][31:0]  tgt_q, tgt_d;

  logic [CNT_W-1:0]         ret_cnt;
  logic [IDX_W-1:0]         ridx;
  logic                     stop;
  logic [IDX_W-1:0]         widx;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      alloc_idx[i] = tail_q + IDX_W'(i);
    end
  end

  assign free_slots = CNT_W'(ROB_SZ) - count_q;

  // Retire prefix: stops at the first not-ready entry, and right after
  // a retiring mispredicted entry (younger entries are on the wrong path).
  always_comb begin
    ret_valid    = '0;
    ret_idx      = '0;
    ret_taken    = '0;
    ret_target   = '0;
    flush        = 1'b0;
    flush_target = '0;
    ret_cnt      = '0;
    stop         = 1'b0;
    ridx         = '0;
    for (int i = 0; i < N; i++) begin
      ridx = head_q + IDX_W'(i);
      if (!stop && alloc_q[ridx] && cmp_q[ridx]) begin
        ret_valid[i]  = 1'b1;
        ret_idx[i]    = ridx;
        ret_taken[i]  = taken_q[ridx];
        ret_target[i] = tgt_q[ridx];
        ret_cnt       = ret_cnt + CNT_W'(1);
        if (misp_q[ridx]) begin
          flush        = 1'b1;
          flush_target = tgt_q[ridx];
          stop         = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    alloc_d = alloc_q;
    cmp_d   = cmp_q;
    misp_d  = misp_q;
    taken_d = taken_q;
    tgt_d   = tgt_q;
    widx    = '0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      alloc_d = '0;
    end else begin
      // Later lanes overwrite earlier ones on an index collision.
      for (int i = 0; i < N; i++) begin
        widx = cmp_idx[i];
        if (cmp_valid[i] && alloc_q[widx]) begin
          cmp_d[widx]   = 1'b1;
          misp_d[widx]  = cmp_mispred[i];
          taken_d[widx] = cmp_taken[i];
          tgt_d[widx]   = cmp_target[i];
        end
      end
      for (int i = 0; i < N; i++) begin
        if (ret_valid[i]) begin
          alloc_d[ret_idx[i]] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (AC_W'(i) < alloc_cnt) begin
          widx          = alloc_idx[i];
          alloc_d[widx] = 1'b1;
          cmp_d[widx]   = 1'b0;
          misp_d[widx]  = 1'b0;
        end
      end
      head_d  = head_q + IDX_W'(ret_cnt);
      tail_d  = tail_q + IDX_W'(alloc_cnt);
      count_d = count_q + CNT_W'(alloc_cnt) - ret_cnt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      cmp_q   <= '0;
      misp_q  <= '0;
      taken_q <= '0;
      tgt_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      alloc_q <= alloc_d;
      cmp_q   <= cmp_d;
      misp_q  <= misp_d;
      taken_q <= taken_d;
      tgt_q   <= tgt_d;
    end
  end

  a_alloc_cnt: assert property (
    @(posedge clock) disable iff (!reset)
    (int'(alloc_cnt) <= N) && (int'(alloc_cnt) <= int'(free_slots))
  );

endmodule

// File: tb/tb_rob_status_table.sv
// tb_rob_status_table: directed vector table plus hand-written sequences
// for wrap-around and mid-run reset of rob_status_table.
module tb_rob_status_table;

  logic                 clock;
  logic                 reset;
  logic [1:0]           alloc_cnt;
  logic [1:0][4:0]      alloc_idx;
  logic [5:0]           free_slots;
  logic [1:0]           cmp_valid;
  logic [1:0][4:0]      cmp_idx;
  logic [1:0]           cmp_mispred;
  logic [1:0]           cmp_taken;
  logic [1:0][31:0]     cmp_target;
  logic [1:0]           ret_valid;
  logic [1:0][4:0]      ret_idx;
  logic [1:0]           ret_taken;
  logic [1:0][31:0]     ret_target;
  logic                 flush;
  logic [31:0]          flush_target;

  int n_chk;
  int n_fail;

  rob_status_table dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_cnt    (alloc_cnt),
    .alloc_idx    (alloc_idx),
    .free_slots   (free_slots),
    .cmp_valid    (cmp_valid),
    .cmp_idx      (cmp_idx),
    .cmp_mispred  (cmp_mispred),
    .cmp_taken    (cmp_taken),
    .cmp_target   (cmp_target),
    .ret_valid    (ret_valid),
    .ret_idx      (ret_idx),
    .ret_taken    (ret_taken),
    .ret_target   (ret_target),
    .flush        (flush),
    .flush_target (flush_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  ac;
    logic [1:0]  cv;
    logic [4:0]  ci0;
    logic [4:0]  ci1;
    logic [1:0]  cm;
    logic [1:0]  ct;
    logic [31:0] cg0;
    logic [31:0] cg1;
    logic [9:0]  e_ai;
    logic [5:0]  e_fs;
    logic [1:0]  e_rv;
    logic [9:0]  e_ri;
    logic [1:0]  e_rt;
    logic [63:0] e_rg;
    logic        e_fl;
    logic [31:0] e_ft;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(
    input logic [1:0] ac, input logic [1:0] cv,
    input logic [4:0] ci0, input logic [4:0] ci1,
    input logic [1:0] cm, input logic [1:0] ct,
    input logic [31:0] cg0, input logic [31:0] cg1,
    input logic [4:0] ai1, input logic [4:0] ai0,
    input logic [5:0] fs, input logic [1:0] rv,
    input logic [4:0] ri1, input logic [4:0] ri0,
    input logic [1:0] rt,
    input logic [31:0] rg1, input logic [31:0] rg0,
    input logic fl, input logic [31:0] ft);
    vec_t v;
    v.ac = ac; v.cv = cv; v.ci0 = ci0; v.ci1 = ci1;
    v.cm = cm; v.ct = ct; v.cg0 = cg0; v.cg1 = cg1;
    v.e_ai = {ai1, ai0}; v.e_fs = fs; v.e_rv = rv;
    v.e_ri = {ri1, ri0}; v.e_rt = rt; v.e_rg = {rg1, rg0};
    v.e_fl = fl; v.e_ft = ft;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    alloc_cnt   = '0;
    cmp_valid   = '0;
    cmp_idx     = '0;
    cmp_mispred = '0;
    cmp_taken   = '0;
    cmp_target  = '0;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, ".alloc_idx"}, 64'(alloc_idx), 64'(v.e_ai));
    chk({tag, ".free_slots"}, 64'(free_slots), 64'(v.e_fs));
    chk({tag, ".ret_valid"}, 64'(ret_valid), 64'(v.e_rv));
    chk({tag, ".ret_idx"}, 64'(ret_idx), 64'(v.e_ri));
    chk({tag, ".ret_taken"}, 64'(ret_taken), 64'(v.e_rt));
    chk({tag, ".ret_target"}, 64'(ret_target), v.e_rg);
    chk({tag, ".flush"}, 64'(flush), 64'(v.e_fl));
    chk({tag, ".flush_target"}, 64'(flush_target), 64'(v.e_ft));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    //           ac cv ci0 ci1 cm ct cg0 cg1 | ai1 ai0 fs rv ri1 ri0 rt rg1 rg0 fl ft
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 32, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(2, 0, 0, 0, 0, 0, 0, 0,      1, 0, 32, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 1, 1, 0, 0, 0, 'h104, 0,  3, 2, 30, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,      3, 2, 30, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 2, 0, 0, 0, 2, 0, 'h200,  3, 2, 30, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,      3, 2, 30, 3, 1, 0, 1, 'h104, 'h200, 0, 0);
    vt[6]  = mk(2, 0, 0, 0, 0, 0, 0, 0,      3, 2, 32, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[7]  = mk(0, 3, 2, 3, 0, 0, 'h300, 'h304, 5, 4, 30, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,      5, 4, 30, 3, 3, 2, 0, 'h304, 'h300, 0, 0);
    vt[9]  = mk(2, 0, 0, 0, 0, 0, 0, 0,      5, 4, 32, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[10] = mk(0, 3, 4, 5, 1, 0, 'h1000, 'h500, 7, 6, 30, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[11] = mk(1, 0, 0, 0, 0, 0, 0, 0,      7, 6, 30, 1, 0, 4, 0, 0, 'h1000, 1, 'h1000);
    vt[12] = mk(0, 1, 5, 0, 0, 0, 'h55, 0,   1, 0, 32, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[13] = mk(1, 0, 0, 0, 0, 0, 0, 0,      1, 0, 32, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[14] = mk(0, 3, 0, 0, 0, 2, 'hA, 'hB,  2, 1, 31, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,      2, 1, 31, 1, 0, 0, 1, 0, 'hB, 0, 0);
    vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,      2, 1, 32, 0, 0, 0, 0, 0, 0, 0, 0);

    idle();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst.free_slots", 64'(free_slots), 64'd32);
    chk("rst.alloc_idx", 64'(alloc_idx), 64'({5'd1, 5'd0}));
    chk("rst.ret_valid", 64'(ret_valid), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 17; k++) begin
      @(negedge clock);
      alloc_cnt     = vt[k].ac;
      cmp_valid     = vt[k].cv;
      cmp_idx[0]    = vt[k].ci0;
      cmp_idx[1]    = vt[k].ci1;
      cmp_mispred   = vt[k].cm;
      cmp_taken     = vt[k].ct;
      cmp_target[0] = vt[k].cg0;
      cmp_target[1] = vt[k].cg1;
      #1;
      check_all($sformatf("v%0d", k), vt[k]);
    end

    // Fill all 32 entries from a fresh reset, then wrap.
    @(negedge clock);
    idle();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      alloc_cnt = 2'd2;
    end
    @(negedge clock);
    idle();
    #1;
    chk("full.free_slots", 64'(free_slots), 64'd0);
    chk("full.alloc_idx", 64'(alloc_idx), 64'({5'd1, 5'd0}));
    cmp_valid  = 2'b11;
    cmp_idx[0] = 5'd0;
    cmp_idx[1] = 5'd1;
    @(negedge clock);
    idle();
    #1;
    chk("full.ret_valid", 64'(ret_valid), 64'd3);
    chk("full.ret_idx", 64'(ret_idx), 64'({5'd1, 5'd0}));
    chk("full.free_still0", 64'(free_slots), 64'd0);
    @(negedge clock);
    #1;
    chk("wrap.free_slots", 64'(free_slots), 64'd2);
    chk("wrap.alloc_idx", 64'(alloc_idx), 64'({5'd1, 5'd0}));
    alloc_cnt = 2'd2;
    @(negedge clock);
    idle();
    #1;
    chk("wrap2.free_slots", 64'(free_slots), 64'd0);
    chk("wrap2.alloc_idx", 64'(alloc_idx), 64'({5'd3, 5'd2}));

    // Mid-run reset with 10 live entries, head one ready to retire.
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      alloc_cnt = 2'd2;
    end
    @(negedge clock);
    idle();
    cmp_valid  = 2'b01;
    cmp_idx[0] = 5'd0;
    @(negedge clock);
    idle();
    #1;
    chk("mid.pre_free", 64'(free_slots), 64'd22);
    chk("mid.pre_ret_valid", 64'(ret_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid.free_slots", 64'(free_slots), 64'd32);
    chk("mid.ret_valid", 64'(ret_valid), 64'd0);
    chk("mid.flush", 64'(flush), 64'd0);
    chk("mid.alloc_idx", 64'(alloc_idx), 64'({5'd1, 5'd0}));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("post.free_slots", 64'(free_slots), 64'd32);
    chk("post.ret_valid", 64'(ret_valid), 64'd0);
    chk("post.alloc_idx", 64'(alloc_idx), 64'({5'd1, 5'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
